pwm_output_gen: RTL

//  Downstream stage of the PWM counter. Compares the counter's count_val against

---
 rtl/pwm_output_gen.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_output_gen.sv
// pwm_output_gen: compare stage following the PWM counter.
// Double-buffers compare/mode settings (swapped only at period boundaries),
// produces the registered PWM level and a one-cycle period_done pulse.
// Optional feature macro: PWM_DEADTIME_EN adds a complementary output with
// dead-time insertion (deadtime input, pwm_out_n output, dead-time FSM).
//
// Dead-time FSM states:
//   state   | meaning
//   IDLE    | channel disabled, both outputs low
//   ON_HI   | pwm_out=1, pwm_out_n=0
//   DT      | dead time, both outputs low while dt_cnt runs down
//   ON_LO   | pwm_out=0, pwm_out_n=1
module pwm_output_gen #(
  parameter int CW  = 16,
  parameter int DTW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwm_en,
  input  logic [CW-1:0] count_val,
  input  logic [CW-1:0] period,
  input  logic          upnotdown,
  input  logic [CW-1:0] compare1,
  input  logic [CW-1:0] compare2,
  input  logic [1:0]    functions,
  output logic          pwm_out,
  output logic          period_done
`ifdef PWM_DEADTIME_EN
  ,
  input  logic [DTW-1:0] deadtime,
  output logic           pwm_out_n
`endif
);

  if (CW < 1 || DTW < 1) begin : g_param_check
    $error("pwm_output_gen: CW and DTW must be at least 1");
  end

  logic [CW-1:0] cnt_prev;
  logic [CW-1:0] cmp1_sh;
  logic [CW-1:0] cmp2_sh;
  logic [1:0]    func_sh;

  logic          wrap;
  logic          load_sh;
  logic [CW-1:0] cmp1_eff;
  logic [CW-1:0] cmp2_eff;
  logic [1:0]    func_eff;
  logic          raw;

  // Boundary detect and shadow selection; a freshly loaded shadow already
  // governs the first count of the new period.
  always_comb begin
    wrap     = (count_val != cnt_prev) &&
               (count_val == (upnotdown ? {CW{1'b0}} : period));
    load_sh  = !pwm_en || wrap;
    cmp1_eff = load_sh ? compare1  : cmp1_sh;
    cmp2_eff = load_sh ? compare2  : cmp2_sh;
    func_eff = load_sh ? functions : func_sh;
  end

  // Raw PWM level: pure unsigned compares, no arithmetic on count_val.
  always_comb begin
    raw = 1'b0;
    if (func_eff[1]) begin
      raw = (cmp1_eff <= count_val) && (count_val < cmp2_eff);
    end else if (func_eff[0]) begin
      raw = (count_val >= cmp1_eff);
    end else begin
      raw = (count_val < cmp1_eff);
    end
  end

  // Previous-count tracker, shadow registers and period boundary pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_prev    <= '0;
      cmp1_sh     <= '0;
      cmp2_sh     <= '0;
      func_sh     <= '0;
      period_done <= 1'b0;
    end else begin
      cnt_prev    <= count_val;
      period_done <= pwm_en && wrap;
      if (load_sh) begin
        cmp1_sh <= compare1;
        cmp2_sh <= compare2;
        func_sh <= functions;
      end
    end
  end

`ifdef PWM_DEADTIME_EN

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON_HI = 2'd1,
    DT    = 2'd2,
    ON_LO = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [DTW-1:0] dt_cnt;
  logic [DTW-1:0] dt_cnt_nx;
  logic           dt_zero;

  // Next-state logic; a zero dead time swaps sides directly without DT.
  always_comb begin
    state_nx  = state;
    dt_cnt_nx = dt_cnt;
    dt_zero   = (deadtime == '0);
    if (!pwm_en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!raw) begin
            state_nx = ON_LO;
          end else if (dt_zero) begin
            state_nx = ON_HI;
          end else begin
            state_nx  = DT;
            dt_cnt_nx = deadtime;
          end
        end
        ON_HI: begin
          if (!raw) begin
            if (dt_zero) begin
              state_nx = ON_LO;
            end else begin
              state_nx  = DT;
              dt_cnt_nx = deadtime;
            end
          end
        end
        ON_LO: begin
          if (raw) begin
            if (dt_zero) begin
              state_nx = ON_HI;
            end else begin
              state_nx  = DT;
              dt_cnt_nx = deadtime;
            end
          end
        end
        DT: begin
          if (dt_cnt == '0) begin
            state_nx = raw ? ON_HI : ON_LO;
          end else begin
            dt_cnt_nx = dt_cnt - DTW'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dt_cnt    <= '0;
      pwm_out   <= 1'b0;
      pwm_out_n <= 1'b0;
    end else begin
      state     <= state_nx;
      dt_cnt    <= dt_cnt_nx;
      pwm_out   <= (state_nx == ON_HI);
      pwm_out_n <= (state_nx == ON_LO);
    end
  end

`else

  // Registered PWM output, forced low while the channel is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= pwm_en && raw;
    end
  end

`endif

endmodule
